// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed response latency
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_strobe,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_data;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic            w_accept;
  logic            w_mis;
  logic [AW-1:0]   w_idx;
  logic            w_unused_addr;

  // Upper address bits alias onto the array; they are intentionally dropped.
  assign w_idx         = req_addr[AW+1:2];
  assign w_unused_addr = ^req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_mis = 1'b0;
    if (req_write) begin
      case (req_strobe)
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111: w_mis = 1'b0;
        default:                   w_mis = 1'b1;
      endcase
    end else begin
      w_mis = (req_addr[1:0] != 2'b00);
    end
  end
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == CW'(1)) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Response payload is captured at acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= CW'(LATENCY - 1);
      r_data <= (req_write || w_mis) ? 32'h0 : r_mem[w_idx];
      r_err  <= w_mis;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - CW'(1);
    end else if (resp_valid && resp_ready) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (req_strobe[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign resp_data = resp_valid ? r_data : 32'h0;
  assign resp_err  = resp_valid & r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
// Expected values depend on whether DMEM_ALIGN_CHECK_EN is defined.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_strobe(req_strobe), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, ".valid"}, {31'b0, resp_valid}, 32'd0);
    check_eq({tag, ".data"}, resp_data, 32'h0);
  endtask

  // One request with resp_ready held high; checks the exact latency window.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    check_eq({tag, ".ready_pre"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_strobe = strb; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom;
    req_wdata = $urandom; req_strobe = 4'hF;
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) @(negedge clk);
      if (c < LAT) begin
        check_eq({tag, ".valid_early"}, {31'b0, resp_valid}, 32'd0);
        check_eq({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
      end else begin
        check_eq({tag, ".valid"}, {31'b0, resp_valid}, 32'd1);
        check_eq({tag, ".data"}, resp_data, exp_d);
        check_eq({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_e});
      end
    end
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_strobe = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check_eq("rst.err", {31'b0, resp_err}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("idle_hold");
    end

    txn("st_full", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("ld_full", 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("st_half", 1'b1, 32'h10, 4'b0011, 32'h00001122, 32'h0, 1'b0);
    txn("ld_half", 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEAD1122, 1'b0);

    // Back-pressure: response must hold while a second request waits.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_strobe = 4'hF; req_wdata = 32'hA5A5A5A5;
    check_eq("stall.wait_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check_eq("stall.valid", {31'b0, resp_valid}, 32'd1);
    check_eq("stall.data", resp_data, 32'hDEAD1122);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall.hold_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("stall.hold_data", resp_data, 32'hDEAD1122);
      check_eq("stall.hold_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_idle("stall.release");
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("stall.second_busy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check_eq("stall.second_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("stall.second_data", resp_data, 32'h0);
    @(negedge clk);
    check_idle("stall.done");
    txn("ld_second", 1'b0, 32'h20, 4'b0000, 32'h0, 32'hA5A5A5A5, 1'b0);

    txn("st_wrap", 1'b1, 32'h1000, 4'b1111, 32'h00000055, 32'h0, 1'b0);
    txn("ld_wrap", 1'b0, 32'h0, 4'b0000, 32'h0, 32'h00000055, 1'b0);

    txn("st_nostrb", 1'b1, 32'h0, 4'b0000, 32'hFFFFFFFF, 32'h0, ALIGN);
    txn("ld_nostrb", 1'b0, 32'h0, 4'b0000, 32'h0, 32'h00000055, 1'b0);

    txn("st_clr30", 1'b1, 32'h30, 4'b1111, 32'h0, 32'h0, 1'b0);
    txn("st_0101", 1'b1, 32'h30, 4'b0101, 32'h11223344, 32'h0, ALIGN);
    txn("ld_0101", 1'b0, 32'h30, 4'b0000, 32'h0, ALIGN ? 32'h0 : 32'h00220044, 1'b0);

    txn("ld_mis", 1'b0, 32'h13, 4'b0000, 32'h0, ALIGN ? 32'h0 : 32'hDEAD1122, ALIGN);

    // Reset in the middle of a transaction; array contents survive.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstwait.busy", {31'b0, req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_idle("rstwait.now");
    check_eq("rstwait.err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rstwait.idle");
    end
    txn("ld_keep", 1'b0, 32'h0, 4'b0000, 32'h0, 32'h00000055, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the data bus driven by the pipeline's memory stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Applies byte-strobed writes to an internal word array.
- Returns one response per request after a fixed, parameterised latency; holds it until the memory stage accepts it.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance to resp_valid; must be >= 1.
- ADDR_W, 32, request address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_strobe  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i]; ignored on loads.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  memory stage accepts the response.
- resp_data  output  32  load data; 0 for stores.
- resp_err  output  1  misaligned access; only when DMEM_ALIGN_CHECK_EN is defined.

Behaviour:
- Reset (reset_n low, any cycle, including mid-transaction):
  - FSM goes to IDLE immediately; req_ready=1, resp_valid=0, resp_data=0, resp_err=0, latency counter=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid && req_ready on edge T.
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Load: the array word is captured into the response register at T.
  - Store: lanes with strobe=1 are written at T; other lanes are untouched. strobe=0000 is a no-op write that still gets a response.
  - Next state is WAIT if LATENCY>1, otherwise RESP. The counter loads LATENCY-1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - Moves to RESP when the counter reaches 1.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable while resp_ready=0.
  - On resp_valid && resp_ready: return to IDLE, drop resp_valid next cycle.
  - No same-cycle re-accept; req_ready stays 0 in RESP.
- Timing:
  - resp_valid rises exactly LATENCY cycles after the accepting edge.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- Request inputs are sampled only at acceptance; later changes while busy are ignored.
- A load issued after a store to the same word returns the post-store value, because the write completes at the store's acceptance edge.
- resp_data is 0 whenever resp_valid=0.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - Checked request sizes: a store whose strobe is not one of 0001/0010/0100/1000/0011/1100/1111 is misaligned. A word load with req_addr[1:0]!=0 is also misaligned.
  - Misaligned stores write nothing.
  - Misaligned loads return resp_data=0.
  - The response for a misaligned request carries resp_err=1; timing is unchanged.
- When undefined:
  - req_addr[1:0] is ignored.
  - Any strobe pattern is written as given.
  - resp_err is tied to 0.

Test Plan:
- Reset then idle → req_ready=1, resp_valid=0, resp_data=0 → held until first request.
- Store addr 0x10, wdata 0xDEADBEEF, strobe 1111; then load addr 0x10 → resp_valid exactly LATENCY cycles after each accept; load resp_data=0xDEADBEEF, store resp_data=0.
- Store addr 0x10, wdata 0x00001122, strobe 0011, over 0xDEADBEEF; then load 0x10 → 0xDEAD1122.
- Load with resp_ready held 0 for 5 cycles → resp_valid and resp_data stable; req_ready=0; a second req_valid is not accepted until one cycle after the response handshake.
- DEPTH_WORDS=1024: store 0x55 to addr 0x1000; then load addr 0x0 → 0x55 (address wrap).
- Assert reset_n low during WAIT → resp_valid=0 and req_ready=1 immediately. With DMEM_ALIGN_CHECK_EN, a load at 0x13 gives resp_err=1, resp_data=0.
